// File: rtl/preem_seq_ctrl.sv
// ---------------------------------------------------------------------------
// preem_seq_ctrl
//
// Sequencing controller for the pre-emphasis path:
//     y[n] = 32*x[n] - 31*x[n-1]   (coefficient (2^SHIFT-1)/2^SHIFT)
// One shared OUT_W-bit add/sub unit is used over several cycles:
//     accept : acc = sext(x) << SHIFT
//     SUB    : acc = acc - (sext(prev) << SHIFT)
//     ADD    : acc = acc + sext(prev), prev = x
//     HOLD   : present acc downstream until out_ready
// Bypass mode loads sext(x) directly and goes straight to HOLD.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   in_data      - IN_W-bit signed sample
//   in_valid     - sample offered
//   in_ready     - high only in IDLE
//   frame_start  - sampled at accept; x[n-1] treated as 0
//   bypass       - sampled at accept; output sign-extended x[n] only
//   out_data     - OUT_W-bit signed result, stable while out_valid
//   out_valid    - result available (HOLD)
//   out_ready    - downstream accepts
//   busy         - high in any state except IDLE
// ---------------------------------------------------------------------------
module preem_seq_ctrl #(
    parameter int unsigned IN_W  = 11,
    parameter int unsigned SHIFT = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  frame_start,
    input  logic                  bypass,
    output logic [IN_W+SHIFT:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    // Output width is tied to the input width and shift so the worst-case
    // result always fits; it is not a free parameter.
    localparam int unsigned OUT_W = IN_W + SHIFT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        ADD  = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  acc_q,   acc_d;
    logic [IN_W-1:0]   prev_q,  prev_d;
    logic [IN_W-1:0]   xcur_q,  xcur_d;

    logic              accept;
    logic [OUT_W-1:0]  in_ext;
    logic [OUT_W-1:0]  in_shl;
    logic [OUT_W-1:0]  prev_ext;
    logic [OUT_W-1:0]  prev_shl;

    // Shared add/sub unit
    logic              alu_sub;
    logic [OUT_W-1:0]  alu_b;
    logic [OUT_W-1:0]  alu_y;

    function automatic logic [OUT_W-1:0] sext(input logic [IN_W-1:0] v);
        return {{(OUT_W-IN_W){v[IN_W-1]}}, v};
    endfunction

    assign in_ext   = sext(in_data);
    assign in_shl   = in_ext << SHIFT;
    assign prev_ext = sext(prev_q);
    assign prev_shl = prev_ext << SHIFT;

    assign accept   = in_valid && (state_q == IDLE);

    // -----------------------------------------------------------------------
    // State register (also holds the datapath registers)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            prev_q  <= '0;
            xcur_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            prev_q  <= prev_d;
            xcur_q  <= xcur_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = bypass ? HOLD : SUB;
                end
            end
            SUB:  state_d = ADD;
            ADD:  state_d = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Shared add/sub: subtract is implemented as add of the inverted operand
    // with carry-in, so one adder serves both SUB and ADD.
    // -----------------------------------------------------------------------
    always_comb begin
        alu_sub = (state_q == SUB);
        alu_b   = alu_sub ? prev_shl : prev_ext;
    end

    assign alu_y = acc_q + (alu_b ^ {OUT_W{alu_sub}}) + {{(OUT_W-1){1'b0}}, alu_sub};

    // -----------------------------------------------------------------------
    // Datapath next-values
    // -----------------------------------------------------------------------
    always_comb begin
        acc_d  = acc_q;
        prev_d = prev_q;
        xcur_d = xcur_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    xcur_d = in_data;
                    if (frame_start) begin
                        prev_d = '0;
                    end
                    if (bypass) begin
                        // History still advances in bypass so toggling
                        // bypass does not break filter continuity.
                        acc_d  = in_ext;
                        prev_d = in_data;
                    end else begin
                        acc_d  = in_shl;
                    end
                end
            end
            SUB: begin
                acc_d = alu_y;
            end
            ADD: begin
                acc_d  = alu_y;
                prev_d = xcur_q;
            end
            HOLD: begin
                acc_d = acc_q;
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        out_data  = acc_q;
    end

endmodule

// File: tb/tb_preem_seq_ctrl.sv
module tb_preem_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [10:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        frame_start;
    logic        bypass;
    logic [16:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;

    preem_seq_ctrl #(.IN_W(11), .SHIFT(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_start (frame_start),
        .bypass      (bypass),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    // Offers one sample, returns observed result and edges from accept to out_valid.
    task automatic run_sample(input int x, input logic fs, input logic byp,
                              output logic [16:0] y, output int lat, output logic got);
        int guard;
        @(negedge clk);
        in_data = x[10:0]; in_valid = 1'b1; frame_start = fs; bypass = byp;
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        in_valid = 1'b0; frame_start = 1'b0; bypass = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        y = out_data; got = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; frame_start = 1'b0;
        bypass = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 17'd0) begin
            failures++;
            $display("FAIL reset: out_valid=%b in_ready=%b busy=%b out_data=%h, expected 0 1 0 00000",
                     out_valid, in_ready, busy, out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [16:0] y; int lat; logic got;
        run_sample(100, 1'b1, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'd3200) begin
            failures++; $display("FAIL basic_fs: y=%0d expected 3200", $signed(y));
        end
        checks++;
        if (lat !== 3) begin
            failures++; $display("FAIL basic_latency: lat=%0d expected 3", lat);
        end
        run_sample(100, 1'b0, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'd100) begin
            failures++; $display("FAIL basic_repeat: y=%0d expected 100", $signed(y));
        end
        run_sample(0, 1'b0, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'(-3100)) begin
            failures++; $display("FAIL basic_zero: y=%0d expected -3100", $signed(y));
        end
    endtask

    task automatic test_extremes();
        logic [16:0] y; int lat; logic got;
        run_sample(-1024, 1'b1, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'(-32768)) begin
            failures++; $display("FAIL ext_min_fs: y=%0d expected -32768", $signed(y));
        end
        run_sample(1023, 1'b0, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'h0FBE0) begin
            failures++; $display("FAIL ext_max: y=%0d expected 64480", $signed(y));
        end
        run_sample(-1024, 1'b0, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'(-64481)) begin
            failures++; $display("FAIL ext_negmax: y=%0d expected -64481", $signed(y));
        end
    endtask

    task automatic test_bypass();
        logic [16:0] y; int lat; logic got;
        run_sample(-1, 1'b0, 1'b1, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'h1FFFF) begin
            failures++; $display("FAIL bypass_data: y=%h expected 1ffff", y);
        end
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL bypass_latency: lat=%0d expected 1", lat);
        end
        run_sample(0, 1'b0, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'd31) begin
            failures++; $display("FAIL bypass_history: y=%0d expected 31", $signed(y));
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] y; int lat; logic got; int hs_base; int guard;
        @(negedge clk);
        out_ready = 1'b0;
        run_sample(10, 1'b1, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'd320) begin
            failures++; $display("FAIL bp_result: y=%0d expected 320", $signed(y));
        end
        hs_base = hs_cnt;
        in_data = 11'd7; in_valid = 1'b1; frame_start = 1'b1; bypass = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== 17'd320) begin
                failures++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b busy=%b out_data=%0d expected 1 0 1 320",
                         i, out_valid, in_ready, busy, $signed(out_data));
            end
        end
        frame_start = 1'b0; bypass = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (hs_cnt - hs_base !== 1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: handshakes=%0d out_valid=%b in_ready=%b expected 1 0 1",
                     hs_cnt - hs_base, out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_accept: busy=%b out_valid=%b expected 1 0", busy, out_valid);
        end
        guard = 0;
        while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 17'(-86)) begin
            failures++; $display("FAIL bp_next: y=%0d expected -86", $signed(out_data));
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] y; int lat; logic got;
        @(negedge clk);
        in_data = 11'd500; in_valid = 1'b1; frame_start = 1'b0; bypass = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL midrst_pre: busy=%b in_ready=%b expected 1 0", busy, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 17'd0) begin
            failures++;
            $display("FAIL midrst_async: out_valid=%b in_ready=%b busy=%b out_data=%h expected 0 1 0 00000",
                     out_valid, in_ready, busy, out_data);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run_sample(50, 1'b0, 1'b0, y, lat, got);
        checks++;
        if (got !== 1'b1 || y !== 17'd1600) begin
            failures++; $display("FAIL midrst_after: y=%0d expected 1600", $signed(y));
        end
    endtask

    task automatic test_streaming();
        int xs[16];
        int expv;
        int in_idx, out_idx, cyc, last_cyc;
        logic will_acc;
        for (int i = 0; i < 16; i++) xs[i] = int'($urandom_range(0, 2047)) - 1024;
        in_idx = 0; out_idx = 0; cyc = 0; last_cyc = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_data = xs[0][10:0]; in_valid = 1'b1; frame_start = 1'b1; bypass = 1'b0;
        while (out_idx < 16 && cyc < 200) begin
            will_acc = in_ready && in_valid;
            if (out_valid) begin
                expv = 32 * xs[out_idx] - ((out_idx == 0) ? 0 : 31 * xs[out_idx-1]);
                checks++;
                if (out_data !== 17'(expv)) begin
                    failures++;
                    $display("FAIL stream[%0d]: y=%0d expected %0d", out_idx, $signed(out_data), expv);
                end
                if (out_idx > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 4) begin
                        failures++;
                        $display("FAIL stream_rate[%0d]: interval=%0d expected 4", out_idx, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                out_idx++;
            end
            @(negedge clk);
            cyc++;
            if (will_acc) begin
                in_idx++;
                frame_start = 1'b0;
                if (in_idx < 16) in_data = xs[in_idx][10:0];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_idx !== 16) begin
            failures++; $display("FAIL stream_count: outputs=%0d expected 16", out_idx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_streaming();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
